// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported synchronous SRAM between instruction fetch and data access.
// One transaction at a time: IDLE issues, BUSY waits out the read latency, DONE pulses valid.
module sram_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,

  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,

  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stallreq_if,
  output logic              stallreq_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  logic [1:0] state;
  logic [1:0] cnt;
  logic       gnt_data;
  logic       last_grant_data;

  logic       pick_data;
  logic       issue;
  logic       issue_wr;

  // Grant decision: on a tie the requester not granted last wins.
  always_comb begin
    pick_data = data_req & (~inst_req | ~last_grant_data);
    issue     = ~rst & (state == S_IDLE) & (inst_req | data_req);
    issue_wr  = pick_data & (data_wen != 4'd0);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = '0;
    if (issue) begin
      mem_en = 1'b1;
      if (pick_data) begin
        mem_wen   = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
      end
    end
  end

  always_comb begin
    inst_valid   = (state == S_DONE) & ~gnt_data;
    data_valid   = (state == S_DONE) &  gnt_data;
    stallreq_if  = inst_req & ~inst_valid;
    stallreq_mem = data_req & ~data_valid;
  end

  // Reset drops any outstanding access; no valid pulse follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 2'd0;
      gnt_data        <= 1'b0;
      last_grant_data <= 1'b0;
      inst_rdata      <= '0;
      data_rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            gnt_data        <= pick_data;
            last_grant_data <= pick_data;
            if (issue_wr) begin
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (cnt == 2'd0) begin
            if (gnt_data) data_rdata <= mem_rdata;
            else          inst_rdata <= mem_rdata;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported synchronous SRAM between the instruction-fetch requester and the data-access requester. It serializes their transactions through a small FSM, returns read data with a one-cycle valid pulse, and raises per-requester stall requests that feed the pipeline stall controller. The block sits between the IF/MEM stages and the unified memory port.

## Interface
- MEM_LAT, 1: SRAM read latency in cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is sampled; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- inst_req  in  1  fetch request; held high with `inst_addr` stable until `inst_valid`.
- inst_addr  in  32  fetch address.
- inst_rdata  out  32  fetched word; valid when `inst_valid`=1, then held until the next capture.
- inst_valid  out  1  one-cycle completion pulse for the fetch.
- data_req  in  1  data request; held high with addr/wen/wdata stable until `data_valid`.
- data_wen  in  4  byte write enables; 0 = read, nonzero = write.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data; valid when `data_valid`=1 for a read, held otherwise.
- data_valid  out  1  one-cycle completion pulse for the data access.
- mem_en  out  1  SRAM enable, one cycle per transaction.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  32  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data.
- stallreq_if  out  1  fetch not yet complete.
- stallreq_mem  out  1  data access not yet complete.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: waiting for SRAM latency; a down-counter tracks the remaining cycles.
  - DONE: the valid pulse is driven.
- IDLE:
  - If any request is high, grant one and drive `mem_en`=1 combinationally in that cycle.
  - The `mem_*` outputs are driven from the granted requester.
  - Go to BUSY with counter = MEM_LAT−1 for a read, or directly to DONE for a write.
- Grant rule:
  - One requester pending: grant it.
  - Both pending: grant the requester not granted last. The `last_grant` register resets to "inst", so data wins the first tie.
  - `last_grant` updates on every grant.
- BUSY:
  - When the counter is 0, capture `mem_rdata` into the granted requester's rdata register and go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - Assert the granted requester's valid for exactly one cycle, then return to IDLE.
  - No new issue occurs in DONE.
  - Requests sampled in DONE are ignored for the completing requester; the requester must drop req in its valid cycle or it is treated as a new request from IDLE.
- A write does not update `data_rdata`.
- `mem_wen`, `mem_addr` and `mem_wdata` are 0 whenever `mem_en`=0. `mem_wen`=0 for fetches.
- Stall requests:
  - `stallreq_if` = `inst_req` & ~`inst_valid`.
  - `stallreq_mem` = `data_req` & ~`data_valid`.
  - Both are combinational and therefore fall in the valid cycle.
- Reset mid-transaction:
  - The FSM returns to IDLE and the counter clears.
  - `last_grant` returns to inst.
  - The outstanding access is dropped and no valid pulse is produced.

## Timing
- Reset values: all outputs 0; `inst_rdata` and `data_rdata` 0.
- Read issued in cycle T: `mem_rdata` sampled at the end of T+MEM_LAT; valid high in T+MEM_LAT+1; IDLE in T+MEM_LAT+2.
- Read occupancy is MEM_LAT+2 cycles (3 for MEM_LAT=1).
- Write issued in cycle T: `data_valid` in T+1; IDLE in T+2.
- Back-to-back transactions: the next `mem_en` is at the earliest one cycle after DONE.
- Simultaneous requests in IDLE: exactly one `mem_en`. The loser's stall request stays high throughout, and it is granted in the next IDLE cycle if still pending.
- A requester is starved for at most one transaction of the other requester.
- A request that rises while the FSM is in BUSY or DONE is served no earlier than the next IDLE.

## Test plan
- Reset, then `inst_req` with `inst_addr`=0xBFC00000, MEM_LAT=1:
  - `mem_en` high in cycle 0 with addr 0xBFC00000 and `mem_wen`=0.
  - `inst_valid` in cycle 2 with `inst_rdata` = `mem_rdata` sampled at the end of cycle 1.
  - `stallreq_if` high in cycles 0–1.
- Both requests in the same cycle after reset, MEM_LAT=1:
  - Data granted first, with `data_valid` in cycle 2.
  - Fetch `mem_en` in cycle 3 and `inst_valid` in cycle 5.
  - `stallreq_if` high in cycles 0–4.
- Data write `data_wen`=4'b1111, `data_addr`=0x100, `data_wdata`=0xDEADBEEF:
  - Single `mem_en` with those values.
  - `data_valid` next cycle.
  - `data_rdata` unchanged.
- MEM_LAT=3 read of 0x40 with SRAM returning 0x12345678:
  - `data_valid` exactly 4 cycles after `mem_en`.
  - `data_rdata`=0x12345678.
- Reset asserted in a BUSY cycle:
  - No valid pulse afterwards.
  - FSM back in IDLE.
  - With `data_req` and `inst_req` both still high, data is granted next.
- Continuous `inst_req` plus repeated `data_req`: grants alternate inst/data, and neither requester waits more than one foreign transaction.
